tdo_drive: RTL
==============

Name: tdo_drive

Overview:
- Drive-side counterpart of the TDI capture path in the executor. Fetches drive-vector bytes from the drive RAM and serializes them onto TDO toward the UUT TDI, one bit per TCK shift strobe.
- Exports the current bit index (dmux_sel) so the capture side stays bit-aligned.
- Sits between the sequencer (start/length) and the external drive RAM (req/ack byte fetch).

Parameters:
- ADDR_W, 16, width of drive-RAM byte address
- LEN_W, 16, width of bit-length field
- LSB_FIRST, 1, 1 = bit0 of each byte shifted first; 0 = bit7 first

Ports:
- master_clk  input  1  system clock; all logic on rising edge
- reset_cpu  input  1  asynchronous, active-low reset
- tck_tick  input  1  one-cycle strobe marking the TCK falling edge (shift point)
- start  input  1  one-cycle pulse to begin a scan
- length  input  LEN_W  number of bits to shift; sampled on accepted start
- ram_req  output  1  byte-fetch request
- a_ram  output  ADDR_W  byte address for the current fetch
- ram_ack  input  1  one-cycle strobe: d_ram_drv valid, request complete
- d_ram_drv  input  8  fetched byte
- tdo  output  1  serial data to UUT
- tdo_en  output  1  high while tdo carries valid data (output-driver enable)
- dmux_sel  output  3  bit index within the current byte
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse at end of scan
- underrun  output  1  sticky error: next byte not fetched in time; cleared on accepted start

Behaviour:
- Reset values: ram_req=0, a_ram=0, tdo=1, tdo_en=0, dmux_sel=0, busy=0, done=0, underrun=0, FSM=IDLE.
- FSM states: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - start with length!=0: latch length; a_ram=0; underrun=0; ram_req=1; go to FETCH.
  - start with length==0: go straight to DONE (no fetch, tdo_en stays 0).
- FETCH:
  - Hold ram_req and a_ram until ram_ack.
  - On ram_ack: load the shifter from d_ram_drv; ram_req=0; go to SHIFT.
  - From the next cycle: tdo = first bit, tdo_en=1, dmux_sel=0.
- SHIFT, on each tck_tick:
  - bit counter +1.
  - If counter reaches length, go to DONE.
  - Otherwise advance to the next bit; dmux_sel +1, wrapping 7->0 at the byte boundary.
- Prefetch:
  - One-byte buffer with a valid flag.
  - While in SHIFT, if the buffer is empty and more bytes are required (bytes_needed = ceil(length/8)), increment a_ram and raise ram_req until ram_ack.
  - ram_ack fills the buffer.
- Byte boundary (tick while dmux_sel==7 and bits remain):
  - Buffer valid: load the shifter from the buffer, clear valid, dmux_sel=0.
  - Buffer empty: underrun=1, abort to DONE. Any outstanding request is dropped (ram_req=0).
- tck_tick and ram_ack in the same cycle: both take effect. The buffer fill and the shift are independent, so a boundary coinciding with an ack uses the acked byte.
- DONE: lasts one cycle; done=1, tdo_en=0, tdo=1, ram_req=0, then back to IDLE. busy is high in FETCH/SHIFT/DONE.
- start while busy is ignored.
- tck_tick outside SHIFT is ignored.
- Bit order: LSB_FIRST=1 uses bit[dmux_sel]; LSB_FIRST=0 uses bit[7-dmux_sel].
- Partial last byte: unused high-order (LSB_FIRST) bits are never shifted.
- Length arithmetic: a_ram never exceeds ceil(length/8)-1. The counter is LEN_W wide and cannot overflow because it stops at length.
- Async reset mid-scan: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: TDO_DRIVE_LAST_BIT_EN.
- Defined: extra output port last_bit (1 bit). It is high exactly while the final bit of the scan is on tdo, so the TAP sequencer can raise TMS for Exit1. Reset value 0; it also goes 0 on underrun abort.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Shared executor package holds:
  - FSM state encoding (IDLE/FETCH/SHIFT/DONE)
  - default ADDR_W/LEN_W constants
  - the bytes_needed function (ceil(len/8))
- One natural sub-module: tdo_drive_fetch. It owns ram_req/a_ram, the prefetch buffer and its valid flag, and exposes buf_valid/buf_data/consume to the shift FSM.

Test Plan:
- Basic shift: length=8, RAM[0]=A5h, LSB_FIRST=1, ack 2 cycles after req, 8 ticks -> tdo sequence 1,0,1,0,0,1,0,1; tdo_en high throughout; done pulse after 8th tick; underrun=0.
- Multi-byte with partial last byte: length=12, RAM[0]=FFh, RAM[1]=00h -> a_ram 0 then 1; tdo eight 1s then four 0s; dmux_sel 0..7,0..3; done after 12th tick; no fetch of address 2.
- MSB-first: LSB_FIRST=0, length=8, RAM[0]=01h -> tdo 0,0,0,0,0,0,0,1.
- Underrun: length=16, withhold ram_ack for byte 1 through the 8th tick -> underrun=1, done pulse, tdo_en=0, ram_req=0; a new start clears underrun.
- Zero length and busy start: start with length=0 -> done in 2 cycles, no ram_req; start during SHIFT ignored (length not relatched).
- Reset mid-scan: assert reset_cpu during SHIFT -> tdo=1, tdo_en=0, busy=0 asynchronously; no done pulse. With TDO_DRIVE_LAST_BIT_EN defined, length=3 -> last_bit high only on the 3rd bit.

Source files
------------

// File: rtl/tdo_drive_pkg.sv
// Shared executor definitions for the TDO drive path: FSM encoding, default widths, byte-count helper.
// No logic of its own; imported by tdo_drive and tdo_drive_fetch.
package tdo_drive_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Number of drive-RAM bytes covering len bits, i.e. ceil(len/8).
  function automatic logic [31:0] bytes_needed(input logic [31:0] len);
    return (len + 32'd7) >> 3;
  endfunction

endpackage

// File: rtl/tdo_drive_fetch.sv
// Drive-RAM byte fetcher with a one-byte prefetch buffer; an ack fills the buffer in the same cycle it can be consumed.
// Holds ram_req/a_ram until ram_ack; stalls prefetch while the buffer is full, drops any request on abort.
module tdo_drive_fetch
  import tdo_drive_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              master_clk,
  input  logic              reset_cpu,
  input  logic              launch,
  input  logic              in_shift,
  input  logic              abort,
  input  logic              consume,
  input  logic [LEN_W-1:0]  nbytes,
  input  logic              ram_ack,
  input  logic [7:0]        d_ram_drv,
  output logic              ram_req,
  output logic [ADDR_W-1:0] a_ram,
  output logic              buf_valid,
  output logic [7:0]        buf_data
);

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic [7:0]        dat_q, dat_d;
  logic              ack_ok;
  logic              fill;
  logic              more;

  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    vld_d  = vld_q;
    dat_d  = dat_q;
    ack_ok = ram_ack && req_q;
    fill   = ack_ok && in_shift;
    more   = (32'(addr_q) + 32'd1) < 32'(nbytes);

    if (launch) begin
      req_d  = 1'b1;
      addr_d = '0;
      vld_d  = 1'b0;
    end else if (abort) begin
      req_d = 1'b0;
      vld_d = 1'b0;
    end else begin
      if (ack_ok) req_d = 1'b0;
      if (fill) begin
        vld_d = 1'b1;
        dat_d = d_ram_drv;
      end
      // A fill and a consume in the same cycle hand the acked byte straight to the shifter.
      if (consume) vld_d = 1'b0;
      if (in_shift && !req_q && !vld_q && more) begin
        req_d  = 1'b1;
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge master_clk or negedge reset_cpu) begin
    if (!reset_cpu) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      vld_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      vld_q  <= vld_d;
      dat_q  <= dat_d;
    end
  end

  assign ram_req   = req_q;
  assign a_ram     = addr_q;
  assign buf_valid = vld_q | fill;
  assign buf_data  = fill ? d_ram_drv : dat_q;

endmodule

// File: rtl/tdo_drive.sv
// Serializes drive-RAM bytes onto TDO, one bit per tck_tick; first bit appears the cycle after the first ram_ack.
// Starts are ignored while busy; a byte missing at a boundary aborts with sticky underrun. TDO_DRIVE_LAST_BIT_EN adds last_bit.
module tdo_drive
  import tdo_drive_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              master_clk,
  input  logic              reset_cpu,
  input  logic              tck_tick,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  output logic              ram_req,
  output logic [ADDR_W-1:0] a_ram,
  input  logic              ram_ack,
  input  logic [7:0]        d_ram_drv,
  output logic              tdo,
  output logic              tdo_en,
  output logic [2:0]        dmux_sel,
`ifdef TDO_DRIVE_LAST_BIT_EN
  output logic              last_bit,
`endif
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       sel_q, sel_d;
  logic             underrun_q, underrun_d;

  logic             launch;
  logic             abort;
  logic             consume;
  logic [LEN_W-1:0] nbytes;
  logic [LEN_W-1:0] cnt_inc;
  logic             buf_valid;
  logic [7:0]       buf_data;
  logic [2:0]       bit_idx;

  assign nbytes  = LEN_W'(bytes_needed(32'(len_q)));
  assign cnt_inc = cnt_q + 1'b1;

  tdo_drive_fetch #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_fetch (
    .master_clk (master_clk),
    .reset_cpu  (reset_cpu),
    .launch     (launch),
    .in_shift   (state_q == ST_SHIFT),
    .abort      (abort),
    .consume    (consume),
    .nbytes     (nbytes),
    .ram_ack    (ram_ack),
    .d_ram_drv  (d_ram_drv),
    .ram_req    (ram_req),
    .a_ram      (a_ram),
    .buf_valid  (buf_valid),
    .buf_data   (buf_data)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    sel_d      = sel_q;
    underrun_d = underrun_q;
    launch     = 1'b0;
    abort      = 1'b0;
    consume    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d      = length;
          cnt_d      = '0;
          sel_d      = '0;
          underrun_d = 1'b0;
          if (length != '0) begin
            launch  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        if (ram_ack) begin
          shreg_d = d_ram_drv;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tck_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            abort   = 1'b1;
            state_d = ST_DONE;
          end else if (sel_q == 3'd7) begin
            if (buf_valid) begin
              shreg_d = buf_data;
              consume = 1'b1;
              sel_d   = '0;
            end else begin
              underrun_d = 1'b1;
              abort      = 1'b1;
              state_d    = ST_DONE;
            end
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge master_clk or negedge reset_cpu) begin
    if (!reset_cpu) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      sel_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      sel_q      <= sel_d;
      underrun_q <= underrun_d;
    end
  end

  assign bit_idx  = LSB_FIRST ? sel_q : (3'd7 - sel_q);
  assign tdo_en   = (state_q == ST_SHIFT);
  assign tdo      = tdo_en ? shreg_q[bit_idx] : 1'b1;
  assign dmux_sel = sel_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign underrun = underrun_q;
`ifdef TDO_DRIVE_LAST_BIT_EN
  // The bit on tdo is number cnt_q+1 of the scan.
  assign last_bit = tdo_en && (cnt_inc == len_q);
`endif

endmodule
